alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Front-end controller for the 8-bit ALU on the board.
//  Debounces two push-buttons and steps one set of switches through operand A, operand B and opcode.
//  Issues a one-cycle valid to the ALU, then captures the result onto the LEDs.
//  Replaces the three-button loading scheme; sits between board I/O and the alu instance.
// PARAMETERS
//  NB_DATA          8        operand/result width, also switch width
//  NB_OPCODE        6        opcode width (taken from i_switch[NB_OPCODE-1:0])
//  NB_DBG_LED       3        loaded-flag LED width
//  NB_STATE         3        state encoding width
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles before a button level is accepted
//  RESULT_TIMEOUT   16       max cycles from issue to i_result_valid
// PORTS
//  i_clock            in   1           system clock
//  i_reset            in   1           synchronous, active-high reset
//  i_switch           in   NB_DATA     board switches (asynchronous)
//  i_btn_load         in   1           load/advance button (asynchronous, active-high)
//  i_btn_clear        in   1           clear button (asynchronous, active-high)
//  i_result           in   NB_DATA     ALU result
//  i_result_valid     in   1           ALU result valid
//  o_first_operator   out  NB_DATA     operand A to ALU
//  o_second_operator  out  NB_DATA     operand B to ALU
//  o_opcode           out  NB_OPCODE   opcode to ALU
//  o_valid            out  1           one-cycle issue strobe to ALU
//  o_led              out  NB_DATA     captured result
//  o_dbg_alu          out  NB_DBG_LED  {a_loaded, b_loaded, op_loaded}
//  o_state            out  NB_STATE    current FSM state (debug)
//  o_error            out  1           result timeout flag
// BEHAVIOUR
//  - Reset: all outputs 0; state ST_WAIT_A; debouncer levels 0; counters 0.
//  - Debounce, per button:
//    - Two-flop synchroniser, then counter.
//    - Accepted level updates only after DEBOUNCE_CYCLES consecutive cycles of a differing synced level.
//    - Any bounce restarts the count.
//    - A rising edge of the accepted level gives a one-cycle pulse: load_p or clear_p.
//  - Press-to-pulse latency is 2 + DEBOUNCE_CYCLES cycles. A held button gives exactly one pulse.
//  - FSM (all outputs registered):
//    - ST_WAIT_A   load_p: o_first_operator <= i_switch, a_loaded <= 1 -> ST_WAIT_B.
//    - ST_WAIT_B   load_p: o_second_operator <= i_switch, b_loaded <= 1 -> ST_WAIT_OP.
//    - ST_WAIT_OP  load_p: o_opcode <= i_switch[NB_OPCODE-1:0], op_loaded <= 1 -> ST_ISSUE.
//    - ST_ISSUE    o_valid = 1 for exactly this cycle; timeout counter <= 0.
//                  If i_result_valid: capture, -> ST_DONE. Otherwise -> ST_WAIT_RES.
//    - ST_WAIT_RES i_result_valid: o_led <= i_result -> ST_DONE.
//                  Otherwise, when counter == RESULT_TIMEOUT-1: o_error <= 1, o_led <= all ones -> ST_ERROR.
//    - ST_DONE     holds o_led. load_p: clears loaded flags, operands and o_led unchanged -> ST_WAIT_A.
//    - ST_ERROR    holds. load_p: o_error <= 0, flags cleared -> ST_WAIT_A.
//  - i_result_valid is accepted only in ST_ISSUE or ST_WAIT_RES and ignored elsewhere.
//  - load_p is ignored in ST_ISSUE and ST_WAIT_RES.
//  - clear_p in any state -> ST_WAIT_A; operands, opcode, o_led, flags and o_error all <= 0.
//  - clear_p wins over a simultaneous load_p or i_result_valid.
//  - i_reset mid-operation, including during o_valid: same values as power-up reset on the next edge.
//  - i_reset also clears debounce counters, so a held button re-qualifies from zero.
//  - Timeout counter is NB bits wide, enough for RESULT_TIMEOUT-1, and does not wrap in ST_WAIT_RES.
//  - Unused state encodings -> ST_WAIT_A with all fields cleared.
// STRUCTURE
//  - Shared header alu_ctrl_defs.vh: ST_* state localparams (NB_STATE wide), NB_DATA/NB_OPCODE defaults, opcode constants.
//  - Sub-module alu_btn_debouncer (synchroniser + counter + edge pulse), instantiated once per button.
//  - This top holds the FSM, operand/opcode/result registers and the timeout counter.
// TESTING (DEBOUNCE_CYCLES=4, RESULT_TIMEOUT=4 in sim; ALU model combinational, i_result_valid = o_valid)
//  1. Clean load sequence, switches 0x05 / 0x03 / 6'b100000 (ADD) -> exactly one o_valid pulse, o_led = 0x08, o_dbg_alu = 3'b111, state ST_DONE.
//  2. Load glitch 0-1-0-1 at 2-cycle spacing, then held 10 cycles -> no pulse during bounce; one pulse only; only operand A captured.
//  3. i_result_valid tied low after issue -> o_error = 1 and o_led = 0xFF exactly 4 cycles after o_valid; load press -> ST_WAIT_A, o_error = 0.
//  4. Clear and load pulses on the same cycle in ST_WAIT_B -> ST_WAIT_A, operands 0, o_dbg_alu = 3'b000.
//  5. i_reset asserted during the ST_ISSUE cycle -> next edge: o_valid = 0, all outputs 0, state ST_WAIT_A; no result captured.
//  6. Load held continuously across ST_DONE -> no extra transition until release and re-press.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_pkg
// Shared definitions for the ALU front-end controller: default widths, the
// FSM state encodings and the opcode values the ALU understands.
// No ports; imported by the sequencer, its debouncer, its interface and the
// testbench.
// ---------------------------------------------------------------------------
package alu_operand_sequencer_pkg;

  // Default operand/result and opcode widths for the board ALU
  localparam int NB_DATA_DEF   = 8;
  localparam int NB_OPCODE_DEF = 6;
  localparam int NB_STATE      = 3;

  // Sequencer states; encoding 3'd7 is unused and recovers to ST_WAIT_A
  localparam logic [NB_STATE-1:0] ST_WAIT_A   = 3'd0;
  localparam logic [NB_STATE-1:0] ST_WAIT_B   = 3'd1;
  localparam logic [NB_STATE-1:0] ST_WAIT_OP  = 3'd2;
  localparam logic [NB_STATE-1:0] ST_ISSUE    = 3'd3;
  localparam logic [NB_STATE-1:0] ST_WAIT_RES = 3'd4;
  localparam logic [NB_STATE-1:0] ST_DONE     = 3'd5;
  localparam logic [NB_STATE-1:0] ST_ERROR    = 3'd6;

  // ALU opcodes (MIPS funct-style encodings)
  localparam logic [NB_OPCODE_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OPCODE_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OPCODE_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OPCODE_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OPCODE_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OPCODE_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OPCODE_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OPCODE_DEF-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_if
// Bus between the operand sequencer (master) and the ALU (slave).
//   o_first_operator   master->slave  operand A
//   o_second_operator  master->slave  operand B
//   o_opcode           master->slave  operation select
//   o_valid            master->slave  one-cycle issue strobe
//   i_result           slave->master  ALU result
//   i_result_valid     slave->master  result qualifier
// Signal names keep the sequencer's point of view.
// ---------------------------------------------------------------------------
interface alu_operand_sequencer_if
  import alu_operand_sequencer_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OPCODE = NB_OPCODE_DEF
) ();

  logic [NB_DATA-1:0]   o_first_operator;
  logic [NB_DATA-1:0]   o_second_operator;
  logic [NB_OPCODE-1:0] o_opcode;
  logic                 o_valid;
  logic [NB_DATA-1:0]   i_result;
  logic                 i_result_valid;

  // Sequencer side: drives operands and the strobe, receives the result
  modport master (
    output o_first_operator, o_second_operator, o_opcode, o_valid,
    input  i_result, i_result_valid
  );

  // ALU side: the mirror image
  modport slave (
    input  o_first_operator, o_second_operator, o_opcode, o_valid,
    output i_result, i_result_valid
  );

endinterface

// File: rtl/alu_operand_sequencer_btn_debouncer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_btn_debouncer
// Synchronises one asynchronous push-button, qualifies its level after
// DEBOUNCE_CYCLES consecutive cycles of a differing synced value, and emits a
// one-cycle pulse on each accepted rising level.
//   i_clock  system clock
//   i_reset  synchronous active-high reset (clears synchroniser and counter)
//   i_btn    raw button, active-high, asynchronous
//   o_pulse  one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module alu_operand_sequencer_btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int NB_CNT = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic              r_sync0;
  logic              r_sync1;
  logic              r_level;
  logic              r_pulse;
  logic [NB_CNT-1:0] r_count;

  // Two-flop synchroniser feeds a counter that only runs while the synced
  // value disagrees with the accepted level; any agreement (a bounce back)
  // restarts it. The pulse is raised on the same edge the level flips to 1,
  // so a held button can never produce a second pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_pulse <= 1'b0;
      if (r_sync1 != r_level) begin
        if (r_count == CNT_LAST) begin
          r_level <= r_sync1;
          r_pulse <= r_sync1;
          r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
// Board front-end for the ALU: one load button steps the switches through
// operand A, operand B and opcode, then a one-cycle strobe is issued and the
// result is captured onto the LEDs. A clear button aborts from anywhere.
//   i_clock      system clock
//   i_reset      synchronous active-high reset
//   i_switch     board switches (asynchronous, sampled on the load pulse)
//   i_btn_load   load/advance button
//   i_btn_clear  clear button
//   io_alu       master side of the ALU bus (operands, opcode, strobe, result)
//   o_led        captured result, all ones after a result timeout
//   o_dbg_alu    {a_loaded, b_loaded, op_loaded}
//   o_state      current FSM state
//   o_error      result timeout flag
// ---------------------------------------------------------------------------
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int NB_DATA         = NB_DATA_DEF,
  parameter int NB_OPCODE       = NB_OPCODE_DEF,
  parameter int NB_DBG_LED      = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESULT_TIMEOUT  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_DATA-1:0]    i_switch,
  input  logic                  i_btn_load,
  input  logic                  i_btn_clear,
  alu_operand_sequencer_if.master io_alu,
  output logic [NB_DATA-1:0]    o_led,
  output logic [NB_DBG_LED-1:0] o_dbg_alu,
  output logic [NB_STATE-1:0]   o_state,
  output logic                  o_error
);

  localparam int NB_TO = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
  localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(RESULT_TIMEOUT - 1);

  logic                  w_loadPulse;
  logic                  w_clearPulse;
  logic [NB_STATE-1:0]   r_state;
  logic [NB_DATA-1:0]    r_firstOperator;
  logic [NB_DATA-1:0]    r_secondOperator;
  logic [NB_OPCODE-1:0]  r_opcode;
  logic                  r_valid;
  logic [NB_DATA-1:0]    r_led;
  logic [NB_DBG_LED-1:0] r_loaded;
  logic                  r_error;
  logic [NB_TO-1:0]      r_timeoutCnt;

  alu_operand_sequencer_btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_debouncer (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_btn  (i_btn_load),
    .o_pulse(w_loadPulse)
  );

  alu_operand_sequencer_btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_debouncer (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_btn  (i_btn_clear),
    .o_pulse(w_clearPulse)
  );

  // Reset, a clear pulse and an unused state encoding all land in the same
  // place: every register zeroed and the FSM back in ST_WAIT_A. Clear is
  // checked ahead of the state case so it beats a coincident load pulse or
  // result strobe. The issue strobe is raised on the edge that enters
  // ST_ISSUE so that it is high for exactly that state's single cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_clearPulse || (r_state > ST_ERROR)) begin
      r_state          <= ST_WAIT_A;
      r_firstOperator  <= '0;
      r_secondOperator <= '0;
      r_opcode         <= '0;
      r_valid          <= 1'b0;
      r_led            <= '0;
      r_loaded         <= '0;
      r_error          <= 1'b0;
      r_timeoutCnt     <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_WAIT_A: begin
          if (w_loadPulse) begin
            r_firstOperator <= i_switch;
            r_loaded[2]     <= 1'b1;
            r_state         <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (w_loadPulse) begin
            r_secondOperator <= i_switch;
            r_loaded[1]      <= 1'b1;
            r_state          <= ST_WAIT_OP;
          end
        end
        ST_WAIT_OP: begin
          if (w_loadPulse) begin
            r_opcode    <= i_switch[NB_OPCODE-1:0];
            r_loaded[0] <= 1'b1;
            r_valid     <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_timeoutCnt <= '0;
          if (io_alu.i_result_valid) begin
            r_led   <= io_alu.i_result;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (io_alu.i_result_valid) begin
            r_led   <= io_alu.i_result;
            r_state <= ST_DONE;
          end else if (r_timeoutCnt == TO_LAST) begin
            r_error <= 1'b1;
            r_led   <= '1;
            r_state <= ST_ERROR;
          end else begin
            r_timeoutCnt <= r_timeoutCnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (w_loadPulse) begin
            r_loaded <= '0;
            r_state  <= ST_WAIT_A;
          end
        end
        ST_ERROR: begin
          if (w_loadPulse) begin
            r_error  <= 1'b0;
            r_loaded <= '0;
            r_state  <= ST_WAIT_A;
          end
        end
        default: r_state <= ST_WAIT_A;
      endcase
    end
  end

  assign io_alu.o_first_operator  = r_firstOperator;
  assign io_alu.o_second_operator = r_secondOperator;
  assign io_alu.o_opcode          = r_opcode;
  assign io_alu.o_valid           = r_valid;
  assign o_led                    = r_led;
  assign o_dbg_alu                = r_loaded;
  assign o_state                  = r_state;
  assign o_error                  = r_error;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_sequencer
// Directed bench for the ALU operand sequencer with a short debounce window
// and result timeout. A combinational ALU model answers every issue strobe
// unless tieLow holds its valid line down.
// ---------------------------------------------------------------------------
module tb_alu_operand_sequencer;
  import alu_operand_sequencer_pkg::*;

  logic       i_clock;
  logic       i_reset;
  logic [7:0] i_switch;
  logic       i_btn_load;
  logic       i_btn_clear;
  logic [7:0] o_led;
  logic [2:0] o_dbg_alu;
  logic [2:0] o_state;
  logic       o_error;
  logic       tieLow;
  logic [7:0] aluResult;

  int vecCount   = 0;
  int missCount  = 0;
  int validCount = 0;

  alu_operand_sequencer_if #(.NB_DATA(8), .NB_OPCODE(6)) alu_if ();

  alu_operand_sequencer #(
    .NB_DATA(8),
    .NB_OPCODE(6),
    .NB_DBG_LED(3),
    .DEBOUNCE_CYCLES(4),
    .RESULT_TIMEOUT(4)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_switch   (i_switch),
    .i_btn_load (i_btn_load),
    .i_btn_clear(i_btn_clear),
    .io_alu     (alu_if.master),
    .o_led      (o_led),
    .o_dbg_alu  (o_dbg_alu),
    .o_state    (o_state),
    .o_error    (o_error)
  );

  // 10 ns clock
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Combinational reference ALU; answers in the same cycle as the strobe
  always_comb begin
    aluResult = 8'h00;
    case (alu_if.o_opcode)
      OP_ADD: aluResult = alu_if.o_first_operator + alu_if.o_second_operator;
      OP_SUB: aluResult = alu_if.o_first_operator - alu_if.o_second_operator;
      OP_AND: aluResult = alu_if.o_first_operator & alu_if.o_second_operator;
      OP_OR:  aluResult = alu_if.o_first_operator | alu_if.o_second_operator;
      OP_XOR: aluResult = alu_if.o_first_operator ^ alu_if.o_second_operator;
      OP_NOR: aluResult = ~(alu_if.o_first_operator | alu_if.o_second_operator);
      default: aluResult = 8'h00;
    endcase
  end

  assign alu_if.i_result       = aluResult;
  assign alu_if.i_result_valid = alu_if.o_valid & ~tieLow;

  // Counts every cycle the issue strobe is seen high
  always @(negedge i_clock) begin
    if (alu_if.o_valid) validCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Press the chosen buttons for holdCycles, release, then let things settle
  task automatic applyStimulus(input logic load, input logic clear,
                               input int holdCycles, input int settleCycles);
    i_btn_load  = load;
    i_btn_clear = clear;
    tick(holdCycles);
    i_btn_load  = 1'b0;
    i_btn_clear = 1'b0;
    tick(settleCycles);
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    tick(3);
    i_reset = 1'b0;
    tick(1);
  endtask

  // Hold load until the issue strobe appears (bounded); button stays held
  task automatic holdUntilIssue(output logic seen);
    seen = 1'b0;
    i_btn_load = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (alu_if.o_valid) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    logic gotErr;
    int   v0;
    int   waitCycles;

    i_reset     = 1'b1;
    i_switch    = 8'h00;
    i_btn_load  = 1'b0;
    i_btn_clear = 1'b0;
    tieLow      = 1'b0;
    tick(3);
    i_reset = 1'b0;
    tick(1);

    // Power-up state
    checkOutput("rst_state", 32'(o_state), 32'(ST_WAIT_A));
    checkOutput("rst_led",   32'(o_led), 32'h00);
    checkOutput("rst_dbg",   32'(o_dbg_alu), 32'h0);
    checkOutput("rst_valid", 32'(alu_if.o_valid), 32'h0);
    checkOutput("rst_error", 32'(o_error), 32'h0);
    checkOutput("rst_opA",   32'(alu_if.o_first_operator), 32'h00);

    // Clean sequence 0x05 + 0x03 with ADD
    i_switch = 8'h05;
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("t1_stateB", 32'(o_state), 32'(ST_WAIT_B));
    checkOutput("t1_opA",    32'(alu_if.o_first_operator), 32'h05);
    checkOutput("t1_dbgA",   32'(o_dbg_alu), 32'h4);
    i_switch = 8'h03;
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("t1_stateOp", 32'(o_state), 32'(ST_WAIT_OP));
    checkOutput("t1_opB",     32'(alu_if.o_second_operator), 32'h03);
    checkOutput("t1_dbgB",    32'(o_dbg_alu), 32'h6);
    v0 = validCount;
    i_switch = 8'h20;
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("t1_validCnt", 32'(validCount - v0), 32'd1);
    checkOutput("t1_opcode",   32'(alu_if.o_opcode), 32'h20);
    checkOutput("t1_led",      32'(o_led), 32'h08);
    checkOutput("t1_dbg",      32'(o_dbg_alu), 32'h7);
    checkOutput("t1_state",    32'(o_state), 32'(ST_DONE));

    // Load held across ST_DONE: one step back to ST_WAIT_A, no further
    i_switch   = 8'h44;
    i_btn_load = 1'b1;
    tick(20);
    checkOutput("t6_stateHeld", 32'(o_state), 32'(ST_WAIT_A));
    checkOutput("t6_dbg",       32'(o_dbg_alu), 32'h0);
    checkOutput("t6_opAKept",   32'(alu_if.o_first_operator), 32'h05);
    checkOutput("t6_ledKept",   32'(o_led), 32'h08);
    i_btn_load = 1'b0;
    tick(8);
    checkOutput("t6_stateRel", 32'(o_state), 32'(ST_WAIT_A));

    // Bouncing load press, then a clean hold: operand A only
    i_switch = 8'h11;
    for (int i = 0; i < 4; i++) begin
      i_btn_load = (i % 2 == 0);
      tick(2);
    end
    checkOutput("t2_noBouncePulse", 32'(o_state), 32'(ST_WAIT_A));
    applyStimulus(1'b1, 1'b0, 10, 8);
    checkOutput("t2_state", 32'(o_state), 32'(ST_WAIT_B));
    checkOutput("t2_opA",   32'(alu_if.o_first_operator), 32'h11);
    checkOutput("t2_opB",   32'(alu_if.o_second_operator), 32'h03);
    checkOutput("t2_dbg",   32'(o_dbg_alu), 32'h4);

    // Clear and load together in ST_WAIT_B: clear wins
    i_switch = 8'h77;
    applyStimulus(1'b1, 1'b1, 8, 8);
    checkOutput("t4_state", 32'(o_state), 32'(ST_WAIT_A));
    checkOutput("t4_opA",   32'(alu_if.o_first_operator), 32'h00);
    checkOutput("t4_opB",   32'(alu_if.o_second_operator), 32'h00);
    checkOutput("t4_dbg",   32'(o_dbg_alu), 32'h0);
    checkOutput("t4_led",   32'(o_led), 32'h00);

    // No result returned: timeout after four cycles in ST_WAIT_RES
    tieLow   = 1'b1;
    i_switch = 8'h0F;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h01;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h20;
    holdUntilIssue(seen);
    checkOutput("t3_issueSeen", 32'(seen), 32'd1);
    waitCycles = 0;
    gotErr     = 1'b0;
    for (int k = 0; k < 12 && !gotErr; k++) begin
      tick(1);
      if (o_error) gotErr = 1'b1;
      else if (o_state == ST_WAIT_RES) waitCycles++;
    end
    checkOutput("t3_waitCycles", 32'(waitCycles), 32'd4);
    checkOutput("t3_error",      32'(o_error), 32'h1);
    checkOutput("t3_led",        32'(o_led), 32'hFF);
    checkOutput("t3_state",      32'(o_state), 32'(ST_ERROR));
    i_btn_load = 1'b0;
    tick(8);
    checkOutput("t3_stateHeld", 32'(o_state), 32'(ST_ERROR));
    tieLow = 1'b0;
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("t3_stateExit", 32'(o_state), 32'(ST_WAIT_A));
    checkOutput("t3_errorExit", 32'(o_error), 32'h0);
    checkOutput("t3_dbgExit",   32'(o_dbg_alu), 32'h0);
    checkOutput("t3_ledExit",   32'(o_led), 32'hFF);

    // Reset during the issue cycle: nothing captured
    i_switch = 8'h02;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h03;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h20;
    holdUntilIssue(seen);
    checkOutput("t5_issueSeen", 32'(seen), 32'd1);
    i_reset = 1'b1;
    tick(1);
    checkOutput("t5_valid", 32'(alu_if.o_valid), 32'h0);
    checkOutput("t5_state", 32'(o_state), 32'(ST_WAIT_A));
    checkOutput("t5_led",   32'(o_led), 32'h00);
    checkOutput("t5_opA",   32'(alu_if.o_first_operator), 32'h00);
    checkOutput("t5_dbg",   32'(o_dbg_alu), 32'h0);
    checkOutput("t5_error", 32'(o_error), 32'h0);
    i_reset = 1'b0;
    tick(8);
    checkOutput("t5_requal", 32'(o_state), 32'(ST_WAIT_B));
    checkOutput("t5_opAReq", 32'(alu_if.o_first_operator), 32'h20);
    i_btn_load = 1'b0;
    tick(8);

    // Two more opcodes from a fresh start
    doReset();
    i_switch = 8'hF0;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h3C;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h24;
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("and_led",   32'(o_led), 32'h30);
    checkOutput("and_state", 32'(o_state), 32'(ST_DONE));
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h0A;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'h03;
    applyStimulus(1'b1, 1'b0, 8, 8);
    i_switch = 8'hE2;
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("sub_opcode", 32'(alu_if.o_opcode), 32'h22);
    checkOutput("sub_led",    32'(o_led), 32'h07);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
